debounce_scheduler: RTL
=======================

Name: debounce_scheduler

Overview:
- Shares one debounce settle timer across N_BTN raw, active-low push-buttons.
- A round-robin scanner finds a button whose synchronized level differs from its debounced state. It then locks the timer to that button and confirms the level is stable for DEBOUNCE_CYCLES.
- On confirmation it commits the new state and emits one-cycle press/release pulses.
- Sits between the board button pins and user logic; replaces per-button debounce counters.

Parameters:
- N_BTN, 4, number of buttons (>=2).
- IDX_W, 2, width of button index; 2**IDX_W >= N_BTN.
- DEBOUNCE_CYCLES, 50000, clocks a new level must hold before commit (>=2).
- CNT_W, 16, settle timer width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_n  input  N_BTN  raw buttons, active-low, asynchronous to clk.
- btn_state  output  N_BTN  debounced level; 1 = pressed.
- press_pulse  output  N_BTN  one-cycle pulse on committed press.
- release_pulse  output  N_BTN  one-cycle pulse on committed release.
- busy  output  1  high while timer is owned (SETTLE or COMMIT).
- active_idx  output  IDX_W  owner index in SETTLE/COMMIT; scan pointer in SCAN.

Behaviour:
- Input sync: 2-FF synchronizer per bit. Synchronizer flops reset to 1 (released). pressed_sync = ~synced.
- Reset values: btn_state=0, press_pulse=0, release_pulse=0, busy=0, active_idx=0, scan ptr=0, timer=0, state=SCAN. All outputs are registered.
- SCAN:
  - Each cycle, test button ptr.
  - If pressed_sync[ptr] != btn_state[ptr]: owner<=ptr, timer<=0, go SETTLE.
  - Else ptr <= ptr+1, wrapping N_BTN-1 -> 0.
- SETTLE:
  - If pressed_sync[owner] == btn_state[owner] (glitch): no commit, no pulse; ptr <= owner+1 (wrap), go SCAN.
  - Else if timer == DEBOUNCE_CYCLES-1: flip btn_state[owner]. Set press_pulse[owner] if new state is 1, else release_pulse[owner]. Go COMMIT.
  - Else timer <= timer+1.
- COMMIT:
  - Exactly one cycle; the pulse is high during this cycle only.
  - Clear pulse, ptr <= owner+1 (wrap), go SCAN.
- Latency: a pin change held stable produces a pulse 2 (sync) + scan wait (0..N_BTN-1) + DEBOUNCE_CYCLES + 1 clocks later.
- Fairness:
  - Changes on non-owner buttons are level-based, so none is lost; they are served in round-robin order after the owner.
  - Worst-case wait is (N_BTN-1)*(DEBOUNCE_CYCLES+2) plus its own settle time.
- Simultaneous changes are served in order starting at the current ptr.
- Short transients: a button that toggles and returns before being scanned produces no event.
- At most one bit of press_pulse|release_pulse is set in any cycle.
- Reset mid-SETTLE aborts with no pulse; btn_state returns to 0.
- busy = (state != SCAN).

Decomposition:
- Package debounce_pkg holds:
  - state enum {SCAN, SETTLE, COMMIT};
  - default parameter constants;
  - a simulation constant DEBOUNCE_CYCLES_SIM = 8.
- One sub-module, btn_sync: parameterized N-bit 2-FF synchronizer with reset-to-1.
- Scheduler FSM, timer and output registers live in the top.

Test Plan (DEBOUNCE_CYCLES=8, N_BTN=4):
- Hold btn_n[1]=0 from a quiet idle state (ptr=0) -> btn_state[1] rises and press_pulse[1] is high for exactly 1 cycle, 12 clocks after the pin edge (2 sync + 1 scan + 8 settle + 1). No other pulses.
- 5-cycle low glitch on btn_n[2] -> busy pulses high. No press_pulse, btn_state stays 0, scanning resumes at index 3.
- Drive btn_n[0] and btn_n[2] low in the same cycle with ptr=0 -> press_pulse[0] first. press_pulse[2] follows 10-11 cycles later; the two are never in the same cycle.
- Release btn_n[1] after a committed press -> release_pulse[1] for one cycle, btn_state[1]=0, press_pulse all 0.
- Press btn_n[3] with ptr reaching 3, commit -> active_idx wraps to 0 in the next SCAN cycle.
- Assert rst_n low at timer=4 during SETTLE on btn 2 -> all outputs 0 immediately. With btn still held after release of reset, a fresh full settle occurs before press_pulse[2].

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state type and default constants for the debounce scheduler
package debounce_pkg;
  typedef enum logic [1:0] {SCAN, SETTLE, COMMIT} state_e;
  localparam int N_BTN_DEF = 4;
  localparam int IDX_W_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF = 16;
  localparam int DEBOUNCE_CYCLES_SIM = 8;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: N-bit two-flop synchronizer whose flops reset to the released level (1)
module btn_sync import debounce_pkg::*; #(
  parameter int N = N_BTN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin sharing of one settle timer across active-low buttons
module debounce_scheduler import debounce_pkg::*; #(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int IDX_W           = IDX_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             busy,
  output logic [IDX_W-1:0] active_idx
);
  logic [N_BTN-1:0] synced, pressed_sync;
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d, active_idx_q, active_idx_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_BTN-1:0] btn_state_q, btn_state_d, press_q, press_d, release_q, release_d;
  logic busy_q, busy_d;

  btn_sync #(.N(N_BTN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_n),
    .q_o   (synced)
  );

  assign pressed_sync = ~synced;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == N_BTN - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    btn_state_d = btn_state_q;
    press_d     = '0;
    release_d   = '0;
    unique case (state_q)
      SCAN:
        if (pressed_sync[ptr_q] != btn_state_q[ptr_q]) begin
          owner_d = ptr_q;
          timer_d = '0;
          state_d = SETTLE;
        end else ptr_d = next_idx(ptr_q);
      SETTLE:
        // a level that reverts before the timer expires is a glitch: drop it silently
        if (pressed_sync[owner_q] == btn_state_q[owner_q]) begin
          ptr_d   = next_idx(owner_q);
          state_d = SCAN;
        end else if (timer_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_state_d[owner_q] = ~btn_state_q[owner_q];
          press_d[owner_q]     = ~btn_state_q[owner_q];
          release_d[owner_q]   = btn_state_q[owner_q];
          state_d              = COMMIT;
        end else timer_d = timer_q + 1'b1;
      COMMIT: begin
        ptr_d   = next_idx(owner_q);
        state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
    busy_d       = state_d != SCAN;
    active_idx_d = (state_d == SCAN) ? ptr_d : owner_d;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= SCAN;
      ptr_q        <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      btn_state_q  <= '0;
      press_q      <= '0;
      release_q    <= '0;
      busy_q       <= 1'b0;
      active_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      btn_state_q  <= btn_state_d;
      press_q      <= press_d;
      release_q    <= release_d;
      busy_q       <= busy_d;
      active_idx_q <= active_idx_d;
    end

  assign btn_state     = btn_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign busy          = busy_q;
  assign active_idx    = active_idx_q;
endmodule
